machine_d_event_logger: RTL and testbench

Downstream consumer of the `machine_d` sequence detector: watches its `F` output and `S` state bus every cycle. On each rising edge of `F` it does two things: it bumps a saturating event counter and captures the concurrent `S` value into a small first-word-fall-through FIFO. A host drains the FIFO through a valid/ready read port. A sticky overflow flag reports any capture dropped while the FIFO was full.

---
 rtl/machine_d_event_logger.sv | 132 +++++++++++++
 tb/tb_machine_d_event_logger.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/machine_d_event_logger.sv
// Event logger for machine_d: counts rising edges of F and queues the concurrent S value in a FWFT FIFO.
// Optional macro LOGGER_TIMESTAMP_EN prepends a free-running cycle timestamp to each entry.
module machine_d_event_logger #(
   parameter int CNT_W = 8,
   parameter int DEPTH = 4,
   parameter int TS_W  = 8
) (
   input  logic                     CLK,
   input  logic                     RESET,
   input  logic                     F,
   input  logic [2:0]               S,
   input  logic                     clr,
   input  logic                     rd_ready,
   output logic                     rd_valid,
`ifdef LOGGER_TIMESTAMP_EN
   output logic [TS_W+2:0]          rd_data,
`else
   output logic [2:0]               rd_data,
`endif
   output logic [$clog2(DEPTH):0]   level,
   output logic [CNT_W-1:0]         event_count,
   output logic                     overflow
);

   localparam int AW = $clog2(DEPTH);
   localparam int LW = AW + 1;
`ifdef LOGGER_TIMESTAMP_EN
   localparam int EW = TS_W + 3;
`else
   localparam int EW = 3;
`endif

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) || (TS_W < 1)) begin : g_bad_param
      $error("machine_d_event_logger: DEPTH must be a power of two >= 2 and TS_W >= 1");
   end

   logic              f_q;
   logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
   logic [LW-1:0]     level_q, level_d;
   logic [CNT_W-1:0]  event_count_q, event_count_d;
   logic              overflow_q, overflow_d;
   logic [EW-1:0]     mem_q [DEPTH];
   logic [EW-1:0]     entry;
   logic              rise, pop, mem_we;

`ifdef LOGGER_TIMESTAMP_EN
   logic [TS_W-1:0]   ts_q, ts_d;

   assign entry = {ts_q, S};

   always_comb begin
      ts_d = ts_q + TS_W'(1);
      if (clr) ts_d = '0;
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) ts_q <= '0;
      else        ts_q <= ts_d;
   end
`else
   assign entry = S;
`endif

   assign rise     = F & ~f_q;
   assign rd_valid = (level_q != '0);
   assign pop      = rd_valid & rd_ready;

   always_comb begin
      wr_ptr_d      = wr_ptr_q;
      rd_ptr_d      = rd_ptr_q;
      level_d       = level_q;
      event_count_d = event_count_q;
      overflow_d    = overflow_q;
      mem_we        = 1'b0;
      if (clr) begin
         wr_ptr_d      = '0;
         rd_ptr_d      = '0;
         level_d       = '0;
         event_count_d = '0;
         overflow_d    = 1'b0;
      end else begin
         if (rise && (event_count_q != '1))
            event_count_d = event_count_q + CNT_W'(1);
         // A pop frees the head slot this edge, so push+pop never overflows even when full.
         if (rise && pop) begin
            mem_we   = 1'b1;
            wr_ptr_d = wr_ptr_q + AW'(1);
            rd_ptr_d = rd_ptr_q + AW'(1);
         end else if (rise) begin
            if (level_q == LW'(DEPTH)) begin
               overflow_d = 1'b1;
            end else begin
               mem_we   = 1'b1;
               wr_ptr_d = wr_ptr_q + AW'(1);
               level_d  = level_q + LW'(1);
            end
         end else if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
            level_d  = level_q - LW'(1);
         end
      end
   end

   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         f_q           <= 1'b0;
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         level_q       <= '0;
         event_count_q <= '0;
         overflow_q    <= 1'b0;
      end else begin
         f_q           <= F;
         wr_ptr_q      <= wr_ptr_d;
         rd_ptr_q      <= rd_ptr_d;
         level_q       <= level_d;
         event_count_q <= event_count_d;
         overflow_q    <= overflow_d;
      end
   end

   always_ff @(posedge CLK) begin
      if (mem_we) mem_q[wr_ptr_q] <= entry;
   end

   assign rd_data     = mem_q[rd_ptr_q];
   assign level       = level_q;
   assign event_count = event_count_q;
   assign overflow    = overflow_q;

endmodule

// File: tb/tb_machine_d_event_logger.sv
// Directed, table-driven bench for machine_d_event_logger, plus a CNT_W=2 instance for saturation.
module tb_machine_d_event_logger;

   logic       clk;
   logic       rst_n;
   logic       f, f2;
   logic [2:0] s;
   logic       clr, rdy;
   logic       rd_valid, rd_valid2;
`ifdef LOGGER_TIMESTAMP_EN
   logic [10:0] rd_data, rd_data2;
`else
   logic [2:0]  rd_data, rd_data2;
`endif
   logic [2:0] level, level2;
   logic [7:0] event_count;
   logic [1:0] event_count2;
   logic       overflow, overflow2;

   int total = 0;
   int bad   = 0;

   machine_d_event_logger dut (
      .CLK(clk), .RESET(rst_n), .F(f), .S(s), .clr(clr), .rd_ready(rdy),
      .rd_valid(rd_valid), .rd_data(rd_data), .level(level),
      .event_count(event_count), .overflow(overflow)
   );

   machine_d_event_logger #(.CNT_W(2)) dut_sat (
      .CLK(clk), .RESET(rst_n), .F(f2), .S(3'b000), .clr(1'b0), .rd_ready(1'b0),
      .rd_valid(rd_valid2), .rd_data(rd_data2), .level(level2),
      .event_count(event_count2), .overflow(overflow2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       f;
      logic [2:0] s;
      logic       clr;
      logic       rdy;
      logic       ev;
      logic [2:0] ed;
      int         el;
      int         ec;
      logic       eo;
   } vec_t;

   vec_t tbl[$];

   task automatic add(input logic vf, input logic [2:0] vs, input logic vclr, input logic vrdy,
                      input logic ev, input logic [2:0] ed, input int el, input int ec, input logic eo);
      vec_t v;
      v.f = vf; v.s = vs; v.clr = vclr; v.rdy = vrdy;
      v.ev = ev; v.ed = ed; v.el = el; v.ec = ec; v.eo = eo;
      tbl.push_back(v);
   endtask

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n = 1'b0; f = 1'b0; f2 = 1'b0; s = 3'd0; clr = 1'b0; rdy = 1'b0;

      //  f  s  clr rdy | valid data level count ovf
      add(1, 3, 0, 0,  1, 3, 1, 1, 0);
      add(0, 0, 0, 1,  0, 0, 0, 1, 0);
      add(1, 7, 0, 0,  1, 7, 1, 2, 0);
      add(1, 6, 0, 0,  1, 7, 1, 2, 0);
      add(1, 5, 0, 0,  1, 7, 1, 2, 0);
      add(1, 5, 0, 1,  0, 0, 0, 2, 0);
      add(1, 5, 0, 0,  0, 0, 0, 2, 0);
      add(0, 1, 0, 0,  0, 0, 0, 2, 0);
      add(1, 1, 0, 0,  1, 1, 1, 3, 0);
      add(0, 0, 0, 0,  1, 1, 1, 3, 0);
      add(1, 2, 0, 0,  1, 1, 2, 4, 0);
      add(0, 0, 0, 0,  1, 1, 2, 4, 0);
      add(1, 3, 0, 0,  1, 1, 3, 5, 0);
      add(0, 0, 0, 0,  1, 1, 3, 5, 0);
      add(1, 4, 0, 0,  1, 1, 4, 6, 0);
      add(0, 0, 0, 0,  1, 1, 4, 6, 0);
      add(1, 5, 0, 0,  1, 1, 4, 7, 1);
      add(0, 0, 0, 1,  1, 2, 3, 7, 1);
      add(0, 0, 0, 1,  1, 3, 2, 7, 1);
      add(0, 0, 0, 0,  1, 3, 2, 7, 1);
      add(1, 2, 1, 1,  0, 0, 0, 0, 0);
      add(1, 3, 0, 0,  0, 0, 0, 0, 0);
      add(0, 0, 0, 0,  0, 0, 0, 0, 0);
      add(1, 1, 0, 0,  1, 1, 1, 1, 0);
      add(0, 0, 0, 0,  1, 1, 1, 1, 0);
      add(1, 2, 0, 0,  1, 1, 2, 2, 0);
      add(0, 0, 0, 0,  1, 1, 2, 2, 0);
      add(1, 3, 0, 0,  1, 1, 3, 3, 0);
      add(0, 0, 0, 0,  1, 1, 3, 3, 0);
      add(1, 4, 0, 0,  1, 1, 4, 4, 0);
      add(0, 0, 0, 0,  1, 1, 4, 4, 0);
      add(1, 5, 0, 1,  1, 2, 4, 5, 0);
      add(0, 0, 0, 1,  1, 3, 3, 5, 0);
      add(0, 0, 0, 1,  1, 4, 2, 5, 0);
      add(0, 0, 0, 1,  1, 5, 1, 5, 0);
      add(0, 0, 0, 1,  0, 0, 0, 5, 0);
      add(0, 0, 0, 1,  0, 0, 0, 5, 0);
      add(1, 6, 0, 1,  1, 6, 1, 6, 0);
      add(0, 0, 0, 0,  1, 6, 1, 6, 0);
      add(1, 7, 0, 0,  1, 6, 2, 7, 0);

      repeat (2) @(posedge clk);
      #1;
      chk("reset rd_valid", rd_valid, 0);
      chk("reset level", level, 0);
      chk("reset event_count", event_count, 0);
      chk("reset overflow", overflow, 0);
      rst_n = 1'b1;

      foreach (tbl[i]) begin
         f = tbl[i].f; s = tbl[i].s; clr = tbl[i].clr; rdy = tbl[i].rdy;
         step();
         chk($sformatf("row%0d rd_valid", i), rd_valid, tbl[i].ev);
         chk($sformatf("row%0d level", i), level, tbl[i].el);
         chk($sformatf("row%0d event_count", i), event_count, tbl[i].ec);
         chk($sformatf("row%0d overflow", i), overflow, tbl[i].eo);
         if (tbl[i].ev) chk($sformatf("row%0d rd_data", i), rd_data[2:0], tbl[i].ed);
      end

      // Async reset with two entries queued must clear outputs before any edge.
      f = 1'b0; clr = 1'b0; rdy = 1'b0;
      #3 rst_n = 1'b0;
      #1;
      chk("async rd_valid", rd_valid, 0);
      chk("async level", level, 0);
      chk("async event_count", event_count, 0);
      step();
      rst_n = 1'b1;

      // F already high at the first edge after reset release counts as a rise.
      f = 1'b1; s = 3'd5;
      step();
      chk("first-edge level", level, 1);
      chk("first-edge event_count", event_count, 1);
      chk("first-edge rd_data", rd_data[2:0], 5);
      f = 1'b0;

`ifdef LOGGER_TIMESTAMP_EN
      #2 rst_n = 1'b0;
      step();
      rst_n = 1'b1;
      f = 1'b0; s = 3'd0;
      repeat (9) step();
      f = 1'b1; s = 3'd2;
      step();
      chk("timestamp ts", rd_data[10:3], 9);
      chk("timestamp S", rd_data[2:0], 2);
      f = 1'b0;
`endif

      for (int k = 1; k <= 5; k++) begin
         f2 = 1'b1;
         step();
         f2 = 1'b0;
         step();
         if (k == 2) chk("sat count after 2", event_count2, 2);
         if (k == 3) chk("sat count after 3", event_count2, 3);
         if (k == 5) chk("sat count after 5", event_count2, 3);
      end
      chk("sat overflow after 5", overflow2, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
